// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared Hack CPU definitions: instruction field bit positions and control FSM state encodings.
package hack_pkg;

    localparam int BIT_CI     = 15;
    localparam int BIT_A      = 12;
    localparam int ALU_SEL_HI = 11;
    localparam int ALU_SEL_LO = 6;
    localparam int D_A        = 5;
    localparam int D_D        = 4;
    localparam int D_M        = 3;
    localparam int J_LT       = 2;
    localparam int J_EQ       = 1;
    localparam int J_GT       = 0;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        EXEC     = 2'd1,
        STALL    = 2'd2
    } state_t;

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// CPU-side bundle: ROM instruction, data memory handshake, and the operand/result wiring to the external ALU.
interface hack_cpu_ctrl_if;
    logic [15:0] instr;
    logic [15:0] in_m;
    logic        mem_rdy;
    logic [15:0] alu_c;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [5:0]  alu_s;
    logic [15:0] out_m;
    logic [14:0] addr_m;
    logic        write_m;
    logic        mem_req;
    logic [15:0] pc;
    logic        stall;

    modport master (
        input  instr, in_m, mem_rdy, alu_c, alu_zr, alu_ng,
        output alu_a, alu_b, alu_s, out_m, addr_m, write_m, mem_req, pc, stall
    );

    modport slave (
        output instr, in_m, mem_rdy, alu_c, alu_zr, alu_ng,
        input  alu_a, alu_b, alu_s, out_m, addr_m, write_m, mem_req, pc, stall
    );
endinterface

// File: rtl/hack_cpu_ctrl_pc.sv
// Program counter: async reset to RST_VAL, load has priority over increment, otherwise holds.
// Single-cycle update; wraps naturally from 16'hFFFF to 16'h0000.
module pc_reg_16 #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     q <= RST_VAL;
        else if (load) q <= d;
        else if (inc)  q <= q + 16'd1;
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: one instruction per cycle, plus one cycle per mem_req & ~mem_rdy cycle.
// A slow data memory holds the FSM in STALL; A, D and pc change only on commit.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int          WIDTH  = 16,
    parameter logic [15:0] PC_RST = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    hack_cpu_ctrl_if.master bus
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, d_reg;
    logic             is_c, need_mem, active, commit, jmp;
    logic             unused_bits;

    assign unused_bits = ^bus.instr[14:13];

    assign is_c     = bus.instr[BIT_CI];
    assign need_mem = is_c & (bus.instr[BIT_A] | bus.instr[D_M]);
    assign active   = (state == EXEC) || (state == STALL);
    assign commit   = active & (~need_mem | bus.mem_rdy);
    assign jmp      = is_c & ((bus.instr[J_LT] & bus.alu_ng) |
                              (bus.instr[J_EQ] & bus.alu_zr) |
                              (bus.instr[J_GT] & ~bus.alu_ng & ~bus.alu_zr));

    assign bus.alu_a   = d_reg;
    assign bus.alu_b   = bus.instr[BIT_A] ? bus.in_m : a_reg;
    assign bus.alu_s   = bus.instr[ALU_SEL_HI:ALU_SEL_LO];
    assign bus.out_m   = bus.alu_c;
    assign bus.addr_m  = a_reg[14:0];
    assign bus.mem_req = need_mem & active;
    assign bus.write_m = commit & is_c & bus.instr[D_M];
    assign bus.stall   = (state == STALL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RST_HOLD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST_HOLD: state_nxt = EXEC;
            EXEC:     state_nxt = commit ? EXEC : STALL;
            STALL:    state_nxt = bus.mem_rdy ? EXEC : STALL;
            default:  state_nxt = RST_HOLD;
        endcase
    end

    // The pc jump target reads a_reg before this commit's d1 write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            d_reg <= '0;
        end else if (commit) begin
            if (!is_c) begin
                a_reg <= bus.instr;
            end else begin
                if (bus.instr[D_A]) a_reg <= bus.alu_c;
                if (bus.instr[D_D]) d_reg <= bus.alu_c;
            end
        end
    end

    pc_reg_16 #(.RST_VAL(PC_RST)) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (commit & jmp),
        .inc   (commit & ~jmp),
        .d     (a_reg),
        .q     (bus.pc)
    );

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl with a behavioural Hack ALU closing the operand/result loop.
module tb_hack_cpu_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    hack_cpu_ctrl_if bus ();

    hack_cpu_ctrl #(.WIDTH(16), .PC_RST(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Hack ALU: zx,nx,zy,ny,f,no
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = bus.alu_s[5] ? 16'h0000 : bus.alu_a;
        ax = bus.alu_s[4] ? ~ax : ax;
        ay = bus.alu_s[3] ? 16'h0000 : bus.alu_b;
        ay = bus.alu_s[2] ? ~ay : ay;
        ao = bus.alu_s[1] ? (ax + ay) : (ax & ay);
        ao = bus.alu_s[0] ? ~ao : ao;
    end
    assign bus.alu_c  = ao;
    assign bus.alu_zr = (ao == 16'h0000);
    assign bus.alu_ng = ao[15];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset       = 1'b1;
        bus.instr   = 16'h0005;
        bus.in_m    = 16'h0000;
        bus.mem_rdy = 1'b1;
        #12;
        check("rst_pc",      bus.pc, 16'h0000);
        check("rst_stall",   {15'd0, bus.stall}, 16'd0);
        check("rst_write_m", {15'd0, bus.write_m}, 16'd0);
        check("rst_mem_req", {15'd0, bus.mem_req}, 16'd0);
        check("rst_d",       bus.alu_a, 16'h0000);
        check("rst_a",       {1'b0, bus.addr_m}, 16'h0000);

        // @5: RST_HOLD swallows one edge, then commits
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("hold_pc", bus.pc, 16'h0000);
        check("hold_mem_req", {15'd0, bus.mem_req}, 16'd0);
        check("at5_write_m", {15'd0, bus.write_m}, 16'd0);
        tick();
        check("at5_pc", bus.pc, 16'h0001);
        check("at5_a",  {1'b0, bus.addr_m}, 16'h0005);

        // D=A
        bus.instr = 16'hEC10;
        #1;
        check("dea_alu_b", bus.alu_b, 16'h0005);
        check("dea_alu_s", {10'd0, bus.alu_s}, 16'h0030);
        check("dea_mem_req", {15'd0, bus.mem_req}, 16'd0);
        tick();
        check("dea_pc", bus.pc, 16'h0002);
        check("dea_d",  bus.alu_a, 16'h0005);

        // M=D with ready memory
        bus.instr = 16'hE308;
        #1;
        check("mwr_write_m", {15'd0, bus.write_m}, 16'd1);
        check("mwr_mem_req", {15'd0, bus.mem_req}, 16'd1);
        check("mwr_addr_m",  {1'b0, bus.addr_m}, 16'h0005);
        check("mwr_out_m",   bus.out_m, 16'h0005);
        tick();
        check("mwr_pc", bus.pc, 16'h0003);

        // D=M with three not-ready cycles
        bus.instr   = 16'hFC10;
        bus.mem_rdy = 1'b0;
        #1;
        check("dm_write_m", {15'd0, bus.write_m}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dm_stall", {15'd0, bus.stall}, 16'd1);
            check("dm_pc_hold", bus.pc, 16'h0003);
        end
        bus.mem_rdy = 1'b1;
        bus.in_m    = 16'h1234;
        #1;
        check("dm_alu_b", bus.alu_b, 16'h1234);
        check("dm_req",   {15'd0, bus.mem_req}, 16'd1);
        tick();
        check("dm_pc", bus.pc, 16'h0004);
        check("dm_d",  bus.alu_a, 16'h1234);
        check("dm_stall_clr", {15'd0, bus.stall}, 16'd0);

        // D;JEQ taken with D=0, not taken with D=1
        bus.instr = 16'h0020; tick();
        check("jeq_pc0", bus.pc, 16'h0005);
        bus.instr = 16'hEA90; tick();
        check("jeq_d0", bus.alu_a, 16'h0000);
        bus.instr = 16'hE302; tick();
        check("jeq_taken", bus.pc, 16'h0020);
        bus.instr = 16'hEFD0; tick();
        check("jeq_d1", bus.alu_a, 16'h0001);
        check("jeq_pc1", bus.pc, 16'h0021);
        bus.instr = 16'hE302; tick();
        check("jeq_not_taken", bus.pc, 16'h0022);

        // A=-1, 0;JMP to 16'hFFFF, then @0 wraps pc
        bus.instr = 16'hEEA0; tick();
        check("wrap_a", {1'b0, bus.addr_m}, 16'h7FFF);
        bus.instr = 16'hEA87; tick();
        check("wrap_jmp", bus.pc, 16'hFFFF);
        bus.instr = 16'h0000; tick();
        check("wrap_pc", bus.pc, 16'h0000);
        check("wrap_a0", {1'b0, bus.addr_m}, 16'h0000);

        // Reset in STALL of a pending M=D
        bus.instr = 16'hEFD0; tick();
        bus.instr = 16'h0007; tick();
        check("sr_a", {1'b0, bus.addr_m}, 16'h0007);
        bus.instr   = 16'hE308;
        bus.mem_rdy = 1'b0;
        #1;
        check("sr_write_m0", {15'd0, bus.write_m}, 16'd0);
        tick();
        check("sr_stall", {15'd0, bus.stall}, 16'd1);
        check("sr_write_m1", {15'd0, bus.write_m}, 16'd0);
        #2;
        reset = 1'b1;
        #1;
        check("sr_stall_drop", {15'd0, bus.stall}, 16'd0);
        check("sr_mem_req",    {15'd0, bus.mem_req}, 16'd0);
        check("sr_pc",         bus.pc, 16'h0000);
        check("sr_d",          bus.alu_a, 16'h0000);
        check("sr_a0",         {1'b0, bus.addr_m}, 16'h0000);
        bus.mem_rdy = 1'b1;
        #1;
        check("sr_write_m2", {15'd0, bus.write_m}, 16'd0);
        tick();
        check("sr_write_m3", {15'd0, bus.write_m}, 16'd0);
        check("sr_pc_hold",  bus.pc, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
